// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM state type and the default word width,
// which is common to the master and the slave.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchronizer followed by a registered level and rise/fall detect.
// Events and level appear SYNC_STAGES+1 clk_i cycles after the pin changes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int N = SYNC_STAGES + 2;

  logic [N-1:0] r_sh;
  logic [N-1:0] r_vld;

  // r_vld marks stages holding real post-reset samples, so a pin that is
  // already at the opposite level when reset lifts never produces an event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sh  <= {N{RESET_VAL}};
      r_vld <= '0;
    end else begin
      r_sh  <= {r_sh[N-2:0], async_i};
      r_vld <= {r_vld[N-2:0], 1'b1};
    end
  end

  assign level_o = r_sh[N-2];
  assign rise_o  = r_vld[N-1] &  r_sh[N-2] & ~r_sh[N-1];
  assign fall_o  = r_vld[N-1] & ~r_sh[N-2] &  r_sh[N-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI Mode 0 subordinate, MSB first: oversamples the SPI pins in clk_i,
// assembles received words and shifts out words from a one-entry TX buffer.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sclk_i,
  input  logic                  ss_ni,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  load_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  spi_done_tick_o,
  output logic                  underrun_o,
  output logic                  busy_o
);

  localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_mosi;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (sclk_i),
    .level_o (w_sclk_level_unused),
    .rise_o  (w_sclk_rise),
    .fall_o  (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (ss_ni),
    .level_o (w_ss_level),
    .rise_o  (w_ss_rise),
    .fall_o  (w_ss_fall)
  );

  // One extra stage keeps MOSI aligned with the registered SCLK events.
  logic [SYNC_STAGES:0] r_mosi_sh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_mosi_sh <= '0;
    else         r_mosi_sh <= {r_mosi_sh[SYNC_STAGES-1:0], mosi_i};
  end

  assign w_mosi = r_mosi_sh[SYNC_STAGES];

  spi_slv_state_e r_state, w_state_nxt;
  logic           w_consume, w_rx_shift, w_tx_shift, w_abort;

  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_buf, r_dout;
  logic [CW-1:0]         r_cnt;
  logic                  r_buf_full, r_done, r_under, r_pend_under;
  logic [DATA_WIDTH-1:0] w_rx_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    w_rx_shift  = 1'b0;
    w_tx_shift  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_consume   = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_ss_rise) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_rx_shift = w_sclk_rise;
          if (w_sclk_fall) begin
            if (r_cnt == '0) w_consume  = 1'b1;
            else             w_tx_shift = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rx_next = {r_rx[DATA_WIDTH-2:0], w_mosi};

  // An empty reload is only reported once the master clocks the first bit of
  // that word, so the reload after a transfer's last word stays silent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx         <= '0;
      r_rx         <= '0;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_done       <= 1'b0;
      r_under      <= 1'b0;
      r_pend_under <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_under <= 1'b0;
      if (w_abort) begin
        r_rx         <= '0;
        r_cnt        <= '0;
        r_pend_under <= 1'b0;
      end
      if (w_rx_shift) begin
        r_rx <= w_rx_next;
        if (r_cnt == LAST_BIT) begin
          r_dout <= w_rx_next;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (r_cnt == '0 && r_pend_under) begin
          r_under      <= 1'b1;
          r_pend_under <= 1'b0;
        end
      end
      if (w_tx_shift) r_tx <= r_tx << 1;
      if (w_consume) begin
        r_tx         <= r_buf_full ? r_buf : '0;
        r_pend_under <= ~r_buf_full;
      end
    end
  end

  // A load coinciding with a consume refills the buffer, so it stays full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (load_i) begin
      r_buf      <= din_i;
      r_buf_full <= 1'b1;
    end else if (w_consume) begin
      r_buf_full <= 1'b0;
    end
  end

  assign miso_o          = (r_state == ACTIVE) & r_tx[DATA_WIDTH-1];
  assign tx_ready_o      = ~r_buf_full;
  assign dout_o          = r_dout;
  assign spi_done_tick_o = r_done;
  assign underrun_o      = r_under;
  assign busy_o          = ~w_ss_level;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core acting as SPI master, with a word-level
// model of the TX buffer and a per-cycle checker of dout_o against expected words.
module tb_spi_slave_core;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       miso, tx_ready, done, under, busy;
  logic [7:0] dout;

  spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .sclk_i          (sclk),
    .ss_ni           (ss_n),
    .mosi_i          (mosi),
    .miso_o          (miso),
    .din_i           (din),
    .load_i          (load),
    .tx_ready_o      (tx_ready),
    .dout_o          (dout),
    .spi_done_tick_o (done),
    .underrun_o      (under),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cnt_tick = 0;
  int cnt_under = 0;
  int exp_under = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_dout = 8'h00;
  logic [7:0] m_buf = 8'h00;
  bit         m_full = 1'b0;
  logic [7:0] tick_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Word-level TX buffer model
  function automatic logic [7:0] m_take(output bit emp);
    if (m_full) begin
      m_full = 1'b0;
      emp = 1'b0;
      return m_buf;
    end
    emp = 1'b1;
    return 8'h00;
  endfunction

  task automatic do_load(input logic [7:0] d);
    din = d;
    load = 1'b1;
    wait_cyc(1);
    load = 1'b0;
    m_buf = d;
    m_full = 1'b1;
  endtask

  // Compare process: dout_o must hold the last expected word except on a tick.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        cnt_tick++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tick: got dout %0h required no tick", dout);
        end else begin
          tick_exp = exp_q.pop_front();
          chk("dout_tick", {24'h0, dout}, {24'h0, tick_exp});
          m_dout = tick_exp;
        end
      end else begin
        chk("dout_hold", {24'h0, dout}, {24'h0, m_dout});
      end
      if (under) cnt_under++;
    end else begin
      m_dout = 8'h00;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_miso"},  {31'h0, miso},     32'h0);
    chk({tag, "_dout"},  {24'h0, dout},     32'h0);
    chk({tag, "_tick"},  {31'h0, done},     32'h0);
    chk({tag, "_under"}, {31'h0, under},    32'h0);
    chk({tag, "_busy"},  {31'h0, busy},     32'h0);
    chk({tag, "_ready"}, {31'h0, tx_ready}, 32'h1);
  endtask

  // Master transfer: n words, the last one cut to last_bits bits.
  // mid_en loads mid_d just after select; coinc_idx loads coinc_d exactly in
  // the cycle the slave reloads after word coinc_idx.
  task automatic xfer(input logic [7:0] mo[4], input int n, input int last_bits,
                      input bit mid_en, input logic [7:0] mid_d,
                      input int coinc_idx, input logic [7:0] coinc_d,
                      output logic [7:0] got[4]);
    logic [7:0] tx;
    logic [7:0] rx;
    bit emp;
    int nb;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    ss_n = 1'b0;
    tx = m_take(emp);
    wait_cyc(HALF);
    chk("ready_after_ss", {31'h0, tx_ready}, {31'h0, !m_full});
    chk("busy_in_xfer", {31'h0, busy}, 32'h1);
    if (mid_en) do_load(mid_d);
    for (int w = 0; w < n; w++) begin
      nb = (w == n - 1) ? last_bits : 8;
      if (emp && nb > 0) exp_under++;
      rx = 8'h00;
      for (int b = 0; b < nb; b++) begin
        mosi = mo[w][7-b];
        wait_cyc(HALF);
        chk("miso_bit", {31'h0, miso}, {31'h0, tx[7-b]});
        rx = {rx[6:0], miso};
        if (b == 7) exp_q.push_back(mo[w]);
        sclk = 1'b1;
        wait_cyc(HALF);
        sclk = 1'b0;
        if (b == 7) begin
          if (w == coinc_idx) begin
            wait_cyc(3);
            din = coinc_d;
            load = 1'b1;
            wait_cyc(1);
            load = 1'b0;
            tx = m_take(emp);
            m_buf = coinc_d;
            m_full = 1'b1;
            wait_cyc(HALF - 4);
          end else begin
            tx = m_take(emp);
            wait_cyc(HALF);
          end
          chk("ready_at_boundary", {31'h0, tx_ready}, {31'h0, !m_full});
        end
      end
      got[w] = rx;
    end
    wait_cyc(HALF);
    ss_n = 1'b1;
    wait_cyc(2 * HALF);
    chk("tick_q_drained", exp_q.size(), 32'h0);
    chk("underrun_count", cnt_under, exp_under);
  endtask

  logic [7:0] mo[4];
  logic [7:0] got[4];
  int tick0, under0;

  initial begin
    wait_cyc(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    wait_cyc(8);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_ready", {31'h0, tx_ready}, 32'h1);

    // T1: single word
    tick0 = cnt_tick;
    do_load(8'hA5);
    chk("t1_ready_after_load", {31'h0, tx_ready}, 32'h0);
    mo = '{8'h3C, 8'h00, 8'h00, 8'h00};
    xfer(mo, 1, 8, 1'b0, 8'h00, -1, 8'h00, got);
    chk("t1_master_rx", {24'h0, got[0]}, 32'hA5);
    chk("t1_dout", {24'h0, dout}, 32'h3C);
    chk("t1_ticks", cnt_tick - tick0, 1);
    chk("t1_ready_end", {31'h0, tx_ready}, 32'h1);

    // T2: back-to-back words, second loaded during the first
    tick0 = cnt_tick; under0 = cnt_under;
    do_load(8'h11);
    mo = '{8'hF0, 8'h0F, 8'h00, 8'h00};
    xfer(mo, 2, 8, 1'b1, 8'h22, -1, 8'h00, got);
    chk("t2_master_rx0", {24'h0, got[0]}, 32'h11);
    chk("t2_master_rx1", {24'h0, got[1]}, 32'h22);
    chk("t2_dout", {24'h0, dout}, 32'h0F);
    chk("t2_ticks", cnt_tick - tick0, 2);
    chk("t2_no_underrun", cnt_under - under0, 0);

    // T3: empty buffer
    tick0 = cnt_tick; under0 = cnt_under;
    mo = '{8'hC3, 8'h00, 8'h00, 8'h00};
    xfer(mo, 1, 8, 1'b0, 8'h00, -1, 8'h00, got);
    chk("t3_master_rx", {24'h0, got[0]}, 32'h00);
    chk("t3_dout", {24'h0, dout}, 32'hC3);
    chk("t3_underrun_once", cnt_under - under0, 1);
    chk("t3_ticks", cnt_tick - tick0, 1);

    // T4: select released after 5 bits, then a full word
    tick0 = cnt_tick;
    do_load(8'h77);
    mo = '{8'hA0, 8'h00, 8'h00, 8'h00};
    xfer(mo, 1, 5, 1'b0, 8'h00, -1, 8'h00, got);
    chk("t4_partial_no_tick", cnt_tick - tick0, 0);
    chk("t4_dout_kept", {24'h0, dout}, 32'hC3);
    do_load(8'h69);
    mo = '{8'h96, 8'h00, 8'h00, 8'h00};
    xfer(mo, 1, 8, 1'b0, 8'h00, -1, 8'h00, got);
    chk("t4_master_rx", {24'h0, got[0]}, 32'h69);
    chk("t4_dout", {24'h0, dout}, 32'h96);

    // T5: overwrite before transfer, load coinciding with a reload
    under0 = cnt_under;
    do_load(8'h01);
    do_load(8'h02);
    chk("t5_ready_full", {31'h0, tx_ready}, 32'h0);
    mo = '{8'h55, 8'hAA, 8'h33, 8'h00};
    xfer(mo, 3, 8, 1'b1, 8'hB7, 0, 8'h4E, got);
    chk("t5_master_rx0", {24'h0, got[0]}, 32'h02);
    chk("t5_master_rx1", {24'h0, got[1]}, 32'hB7);
    chk("t5_master_rx2", {24'h0, got[2]}, 32'h4E);
    chk("t5_dout", {24'h0, dout}, 32'h33);
    chk("t5_no_underrun", cnt_under - under0, 0);

    // T6: reset in mid-word, then select still low after release
    tick0 = cnt_tick; under0 = cnt_under;
    do_load(8'hE1);
    ss_n = 1'b0;
    void'(m_take(m_full));
    m_full = 1'b0;
    wait_cyc(HALF);
    do_load(8'h3F);
    mosi = 1'b1;
    sclk = 1'b1;
    wait_cyc(3);
    chk("t6_pre_miso", {31'h0, miso}, 32'h1);
    chk("t6_pre_busy", {31'h0, busy}, 32'h1);
    chk("t6_pre_ready", {31'h0, tx_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    m_full = 1'b0;
    exp_q.delete();
    @(negedge clk);
    sclk = 1'b0;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(10);
    do_load(8'hFF);
    for (int b = 0; b < 8; b++) begin
      mosi = b[0];
      wait_cyc(HALF);
      chk("t6_idle_miso", {31'h0, miso}, 32'h0);
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
    wait_cyc(10);
    chk("t6_not_consumed", {31'h0, tx_ready}, 32'h0);
    chk("t6_no_tick", cnt_tick - tick0, 0);
    chk("t6_no_underrun", cnt_under - under0, 0);
    chk("t6_dout_reset", {24'h0, dout}, 32'h00);
    ss_n = 1'b1;
    wait_cyc(2 * HALF);
    mo = '{8'h5A, 8'h00, 8'h00, 8'h00};
    xfer(mo, 1, 8, 1'b0, 8'h00, -1, 8'h00, got);
    chk("t6_master_rx", {24'h0, got[0]}, 32'hFF);
    chk("t6_dout", {24'h0, dout}, 32'h5A);

    wait_cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
